// File: rtl/matrix_sum_row_collector_if.sv
// Row-in / element-out handshake bundle for matrix_sum_row_collector.
// Both streams transfer on a clock edge where valid and ready are high together; valid never waits on ready.
interface matrix_sum_row_collector_if #(
    parameter int DATA_WIDTH = 11,
    parameter int COLS       = 12,
    parameter int ROW_W      = 4,
    parameter int COL_W      = 4
);
    logic                         inValid;
    logic                         inReady;
    logic [ROW_W-1:0]             inRowNo;
    logic [COLS*DATA_WIDTH-1:0]   inRow;
    logic                         outValid;
    logic                         outReady;
    logic signed [DATA_WIDTH-1:0] outData;
    logic [ROW_W-1:0]             outRowNo;
    logic [COL_W-1:0]             outColNo;
    logic                         outLast;
    logic                         matrixDone;
    logic                         seqError;

    modport master (
        output inValid, inRowNo, inRow, outReady,
        input  inReady, outValid, outData, outRowNo, outColNo, outLast, matrixDone, seqError
    );

    modport slave (
        input  inValid, inRowNo, inRow, outReady,
        output inReady, outValid, outData, outRowNo, outColNo, outLast, matrixDone, seqError
    );
endinterface

// File: rtl/matrix_sum_row_collector.sv
// Ping-pong matrix collector: rows fill one bank while the other drains as a row-major element stream.
// Optional row-tag sequence check is built when ROW_SEQ_CHECK_EN is defined.
module matrix_sum_row_collector #(
    parameter int DATA_WIDTH = 11,
    parameter int ROWS       = 10,
    parameter int COLS       = 12,
    parameter int ROW_W      = 4,
    parameter int COL_W      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    matrix_sum_row_collector_if.slave bus
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic signed [DATA_WIDTH-1:0] mem [2][ROWS][COLS];

    logic             wb;
    logic             rb;
    logic [1:0]       full;
    logic [ROW_W-1:0] exp_row;
    logic [ROW_W-1:0] row_ptr;
    logic [COL_W-1:0] col_ptr;
    logic             matrix_done;
    logic             seq_error;

    logic accept;
    logic drain;
    logic last_elem;

    assign accept    = bus.inValid & bus.inReady;
    assign drain     = bus.outValid & bus.outReady;
    assign last_elem = (row_ptr == LAST_ROW) && (col_ptr == LAST_COL);

    assign bus.inReady    = enable & ~full[wb];
    assign bus.outValid   = enable & full[rb];
    assign bus.outData    = mem[rb][row_ptr][col_ptr];
    assign bus.outRowNo   = row_ptr;
    assign bus.outColNo   = col_ptr;
    assign bus.outLast    = bus.outValid & last_elem;
    assign bus.matrixDone = matrix_done;
    assign bus.seqError   = seq_error;

    // Bank storage has no reset; rows are placed by the fill pointer, never by the tag.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            for (int c = 0; c < COLS; c++) begin
                mem[wb][exp_row][c] <= bus.inRow[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb          <= 1'b0;
            rb          <= 1'b0;
            full        <= 2'b00;
            exp_row     <= '0;
            row_ptr     <= '0;
            col_ptr     <= '0;
            matrix_done <= 1'b0;
        end else begin
            matrix_done <= drain & last_elem;
            if (accept) begin
                if (exp_row == LAST_ROW) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                    exp_row  <= '0;
                end else begin
                    exp_row <= exp_row + ROW_W'(1);
                end
            end
            // Fill and drain always target different banks, so both flag writes may land together.
            if (drain) begin
                if (last_elem) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                    row_ptr  <= '0;
                    col_ptr  <= '0;
                end else if (col_ptr == LAST_COL) begin
                    col_ptr <= '0;
                    row_ptr <= row_ptr + ROW_W'(1);
                end else begin
                    col_ptr <= col_ptr + COL_W'(1);
                end
            end
        end
    end

`ifdef ROW_SEQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_error <= 1'b0;
        end else if (accept && (bus.inRowNo != exp_row)) begin
            seq_error <= 1'b1;
        end
    end
`else
    logic unused_row_no;
    assign unused_row_no = ^bus.inRowNo;
    assign seq_error     = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_sum_row_collector.sv
// Scoreboard bench for matrix_sum_row_collector: accepted rows push expected elements, the drain monitor pops them.
module tb_matrix_sum_row_collector;
  localparam int DW    = 11;
  localparam int ROWS  = 10;
  localparam int COLS  = 12;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int W     = 1 + ROW_W + COL_W + DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  matrix_sum_row_collector_if #(.DATA_WIDTH(DW), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  matrix_sum_row_collector #(
    .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int errors = 0;
  int m_row = 0;
  int elem_cnt = 0;
  int done_count = 0;
  logic done_exp = 1'b0;

`ifdef ROW_SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  // Drain monitor: mid-cycle sampling, transfer happens at the next rising edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    if (reset) begin
      done_exp = 1'b0;
    end else begin
      vectors++;
      if (bus.matrixDone !== done_exp) begin
        errors++;
        $display("FAIL matrix_done: got %b expected %b at %0t", bus.matrixDone, done_exp, $time);
      end
      if (bus.matrixDone) done_count++;
      done_exp = 1'b0;
      if (bus.outValid && bus.outReady) begin
        got = {bus.outLast, bus.outRowNo, bus.outColNo, bus.outData};
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL drain_unexpected: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL drain_elem: got last=%b row=%0d col=%0d data=%0d expected last=%b row=%0d col=%0d data=%0d",
                     got[W-1], got[W-2 -: ROW_W], got[DW+COL_W-1 -: COL_W], $signed(got[DW-1:0]),
                     e[W-1], e[W-2 -: ROW_W], e[DW+COL_W-1 -: COL_W], $signed(e[DW-1:0]));
          end
        end
        elem_cnt++;
        if (bus.outLast) done_exp = 1'b1;
      end
    end
  end

  task automatic send_row(input logic [COLS*DW-1:0] row, input logic [ROW_W-1:0] tag);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    bus.inValid = 1'b1;
    bus.inRow = row;
    bus.inRowNo = tag;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.inReady;
      @(posedge clk);
      #1;
      n++;
    end
    bus.inValid = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL send_row_timeout: got no accept expected accept for row %0d", m_row);
    end else begin
      for (int c = 0; c < COLS; c++) begin
        logic lst;
        lst = (m_row == ROWS - 1) && (c == COLS - 1);
        exp_q.push_back({lst, ROW_W'(m_row), COL_W'(c), row[c*DW +: DW]});
      end
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end
  endtask

  function automatic logic [COLS*DW-1:0] rand_row();
    logic [COLS*DW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*DW +: DW] = DW'($urandom_range(0, 2047));
    return r;
  endfunction

  function automatic logic [COLS*DW-1:0] idx_row(input int r);
    logic [COLS*DW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'(r * COLS + c);
    return v;
  endfunction

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inValid = 1'b0;
    bus.outReady = 1'b0;
    bus.inRow = '0;
    bus.inRowNo = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.outValid !== 1'b0 || bus.outLast !== 1'b0 || bus.inReady !== 1'b1 ||
        bus.matrixDone !== 1'b0 || bus.seqError !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b l=%b r=%b d=%b s=%b expected v=0 l=0 r=1 d=0 s=0",
               bus.outValid, bus.outLast, bus.inReady, bus.matrixDone, bus.seqError);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_one();
    int d0;
    d0 = done_count;
    bus.outReady = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (bus.outValid !== 1'b0) begin
        errors++;
        $display("FAIL fill_early_valid: got %b expected 0 before row %0d", bus.outValid, r);
      end
      send_row(idx_row(r), ROW_W'(r));
    end
    vectors++;
    if (bus.outValid !== 1'b1) begin
      errors++;
      $display("FAIL fill_latency: got outValid=%b expected 1", bus.outValid);
    end
    wait_drain();
    vectors++;
    if (done_count - d0 != 1 || bus.seqError !== 1'b0) begin
      errors++;
      $display("FAIL fill_done_pulses: got %0d seq=%b expected 1 seq=0", done_count - d0, bus.seqError);
    end
  endtask

  task automatic test_ping_pong();
    int n;
    logic seen;
    bus.outReady = 1'b0;
    for (int r = 0; r < 2 * ROWS; r++) send_row(rand_row(), ROW_W'(r % ROWS));
    bus.inValid = 1'b1;
    bus.inRow = rand_row();
    bus.inRowNo = '0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.inReady !== 1'b0) begin
        errors++;
        $display("FAIL both_full_ready: got %b expected 0", bus.inReady);
      end
      @(posedge clk);
      #1;
    end
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      seen = bus.outValid && bus.outLast;
      n++;
    end
    vectors++;
    if (!seen || bus.inReady !== 1'b0) begin
      errors++;
      $display("FAIL pp_before_last: got seen=%b ready=%b expected seen=1 ready=0", seen, bus.inReady);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.inReady !== 1'b1) begin
      errors++;
      $display("FAIL pp_ready_return: got %b expected 1", bus.inReady);
    end
    wait_drain();
  endtask

  task automatic test_negative();
    logic [COLS*DW-1:0] v;
    bus.outReady = 1'b1;
    v = {COLS{11'h400}};
    send_row(v, 4'd0);
    v = {COLS{11'h3FF}};
    send_row(v, 4'd1);
    for (int r = 2; r < ROWS; r++) send_row(rand_row(), ROW_W'(r));
    wait_drain();
  endtask

  task automatic test_seq_error();
    bus.outReady = 1'b0;
    send_row(rand_row(), 4'd0);
    send_row(rand_row(), 4'd1);
    vectors++;
    if (bus.seqError !== 1'b0) begin
      errors++;
      $display("FAIL seq_before: got %b expected 0", bus.seqError);
    end
    send_row(idx_row(77), 4'd3);
    vectors++;
    if (bus.seqError !== SEQ_ON) begin
      errors++;
      $display("FAIL seq_set: got %b expected %b", bus.seqError, SEQ_ON);
    end
    for (int r = 3; r < ROWS; r++) send_row(rand_row(), ROW_W'(r));
    bus.outReady = 1'b1;
    wait_drain();
    vectors++;
    if (bus.seqError !== SEQ_ON) begin
      errors++;
      $display("FAIL seq_sticky: got %b expected %b", bus.seqError, SEQ_ON);
    end
  endtask

  task automatic test_enable();
    int n;
    int base;
    bus.outReady = 1'b1;
    for (int r = 0; r < 4; r++) send_row(rand_row(), ROW_W'(r));
    enable = 1'b0;
    bus.inValid = 1'b1;
    bus.inRow = rand_row();
    bus.inRowNo = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.inReady !== 1'b0) begin
        errors++;
        $display("FAIL enable_fill_ready: got %b expected 0", bus.inReady);
      end
    end
    bus.inValid = 1'b0;
    enable = 1'b1;
    for (int r = 4; r < ROWS; r++) send_row(rand_row(), ROW_W'(r));
    base = elem_cnt;
    n = 0;
    while (elem_cnt - base < 50 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.outValid !== 1'b0 || bus.outRowNo !== 4'd4 || bus.outColNo !== 4'd2) begin
        errors++;
        $display("FAIL enable_drain_hold: got v=%b row=%0d col=%0d expected v=0 row=4 col=2",
                 bus.outValid, bus.outRowNo, bus.outColNo);
      end
    end
    enable = 1'b1;
    wait_drain();
  endtask

  task automatic test_mid_reset();
    bus.outReady = 1'b0;
    for (int r = 0; r < ROWS + 5; r++) send_row(rand_row(), ROW_W'(r % ROWS));
    reset = 1'b1;
    bus.inValid = 1'b1;
    bus.inRow = rand_row();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.inValid = 1'b0;
    exp_q.delete();
    m_row = 0;
    vectors++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1 || bus.seqError !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b r=%b s=%b expected v=0 r=1 s=0",
               bus.outValid, bus.inReady, bus.seqError);
    end
    bus.outReady = 1'b1;
    for (int r = 0; r < ROWS; r++) send_row(rand_row(), ROW_W'(r));
    wait_drain();
  endtask

  initial begin
    bus.inValid = 1'b0;
    bus.outReady = 1'b0;
    bus.inRow = '0;
    bus.inRowNo = '0;
    test_reset();
    test_fill_one();
    test_ping_pong();
    test_negative();
    test_seq_error();
    test_enable();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/matrix_sum_row_collector.md
Name: matrix_sum_row_collector

Overview:
- Receive-side endpoint for the vector-add matrix datapath.
- Accepts one summed row-vector per handshake, tagged with its row number, and assembles a full ROWS x COLS result matrix into one of two ping-pong banks.
- Drains a completed bank as a serial element stream (row-major) with a valid/ready handshake, so the next matrix can be captured while the previous one drains.

Parameters:
DATA_WIDTH, 11, width of each signed sum element (adder IN_WIDTH+1)
ROWS, 10, row-vectors per matrix
COLS, 12, elements per row-vector
ROW_W, 4, width of row-number fields (must satisfy 2^ROW_W >= ROWS)
COL_W, 4, width of column-number field (must satisfy 2^COL_W >= COLS)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  global advance; when low, all state holds and no transfers occur
inValid  in  1  row-vector present (driven from adder outReady)
inReady  out  1  collector can accept a row; = enable & !full[wb]
inRowNo  in  ROW_W  row index tag of presented row (adder vectorSetOutNo)
inRow  in  COLS*DATA_WIDTH  packed signed row; element c at bits [c*DATA_WIDTH +: DATA_WIDTH]
outValid  out  1  element available; = enable & full[rb]
outReady  in  1  downstream accepts element
outData  out  DATA_WIDTH  signed element bank[rb][rowPtr][colPtr]
outRowNo  out  ROW_W  rowPtr of current element
outColNo  out  COL_W  colPtr of current element
outLast  out  1  high with the final element (row ROWS-1, col COLS-1)
matrixDone  out  1  one-cycle pulse, the cycle after the last element transfers
seqError  out  1  sticky: a row arrived with an unexpected inRowNo

Behaviour:
- Storage: two banks of ROWS x COLS x DATA_WIDTH registers. State per bank: full[0..1]. Pointers: write bank wb, read bank rb, expRow (fill), rowPtr/colPtr (drain).
- Reset: wb=rb=0, full=0, expRow=0, rowPtr=colPtr=0, seqError=0, matrixDone=0. Resulting outputs: outValid=0, outLast=0, inReady=enable. Bank contents are not reset; outData is don't-care while outValid=0.
- Accept: occurs when inValid & inReady.
  - All COLS elements are written to bank[wb][expRow].
  - If expRow==ROWS-1: full[wb]<=1, wb toggles, expRow<=0. Otherwise expRow increments.
- Row tag: the row is always stored at expRow. inRowNo only feeds the sequence check (see Optional Feature).
- Drain: occurs when outValid & outReady.
  - Column wrap: colPtr increments; at COLS-1 it wraps to 0 and rowPtr increments.
  - Last element (rowPtr==ROWS-1 and colPtr==COLS-1): full[rb]<=0, rb toggles, pointers go to 0, matrixDone<=1 on the next cycle.
- outData/outRowNo/outColNo are combinational reads of registered state. Latency from the last-row accept to outValid is 1 cycle. One element per cycle sustained.
- Backpressure: with both banks full, inReady=0. It reasserts the cycle after the draining bank's last element transfers.
- Simultaneous fill-complete on one bank and drain-complete on the other in the same cycle is legal: both flags update. The same bank can never be set and cleared in one cycle, because set requires !full.
- enable low: no accepts, no drains, pointers and flags hold. matrixDone still self-clears.
- Reset mid-operation discards partial and full banks. inRow arriving during reset is ignored.

Optional Feature:
ROW_SEQ_CHECK_EN
- Defined: on each accept, if inRowNo != expRow, seqError<=1. seqError is sticky until reset. The row is still stored at expRow.
- Undefined: inRowNo is ignored, no compare logic is built, and seqError is tied 0.

Test Plan:
- Fill one matrix: 10 rows, row r element c = r*12+c, tags 0..9, outReady=1 -> outValid 1 cycle after row 9; 120 elements stream 0..119 in order; outLast on element 119; matrixDone pulses once; seqError=0.
- Ping-pong with stalled drain, outReady=0: send 20 rows -> inReady drops after row 19 and stays 0 for row 20. Raise outReady -> inReady returns the cycle after element 119 of bank 0 drains; bank 1 then streams.
- Negative values: row 0 all -1024 (11-bit min), row 1 all +1023 -> outData reproduces -1024/+1023 exactly, sign intact.
- Sequence error (macro on): tags 0,1,3 -> seqError=1 from the cycle after the third accept. That row appears as outRowNo=2. seqError persists until reset. With macro off, seqError stays 0.
- enable toggled low during the fill (row 4) and during the drain (element 50) -> no pointer movement while low; the stream resumes identically.
- Reset asserted after 5 rows plus a full bank -> outValid=0 and inReady=1 next cycle. A fresh 10-row matrix then drains starting at outRowNo=0, outColNo=0.
